mem_arbiter: RTL

- Single owner of the byte-wide RAM/IO port.
- Arbitrates between the instruction-fetch unit (fixed 4-byte reads) and the load/store buffer (1/2/4-byte loads and stores issued at commit).
- Serialises each access into byte beats, assembles or extends load results, and stalls IO writes on io_buffer_full.
- Sits between the fetcher/LSB and the top-level RAM wrapper.

---
 rtl/mem_arbiter_pkg.sv | 54 +++++
 rtl/mem_arbiter_load_extend.sv | 32 +++
 rtl/mem_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared definitions for the memory arbiter: load/store op
//               codes, arbiter state encodings, the op -> beat-count decode
//               and the IO-select test on the address select field.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // Load/store op codes carried on ls_op
    localparam logic [6:0] c_op_lb  = 7'd1;
    localparam logic [6:0] c_op_lh  = 7'd2;
    localparam logic [6:0] c_op_lw  = 7'd3;
    localparam logic [6:0] c_op_lbu = 7'd4;
    localparam logic [6:0] c_op_lhu = 7'd5;
    localparam logic [6:0] c_op_sb  = 7'd6;
    localparam logic [6:0] c_op_sh  = 7'd7;
    localparam logic [6:0] c_op_sw  = 7'd8;

    // Arbiter state encodings
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_load  = 2'd2;
    localparam logic [1:0] c_st_store = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_st_idle,
        ST_FETCH = c_st_fetch,
        ST_LOAD  = c_st_load,
        ST_STORE = c_st_store
    } state_t;

    // Value of the address select field that marks an IO access
    localparam logic [1:0] c_io_sel = 2'b11;

    // Instruction fetches are always full words
    localparam logic [2:0] c_fetch_beats = 3'd4;

    // Number of byte beats an op needs
    function automatic logic [2:0] op_beats(input logic [6:0] op);
        case (op)
            c_op_lb, c_op_lbu, c_op_sb: return 3'd1;
            c_op_lh, c_op_lhu, c_op_sh: return 3'd2;
            default:                    return 3'd4;
        endcase
    endfunction

    function automatic logic is_io_sel(input logic [1:0] sel);
        return (sel == c_io_sel);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_extend
// Description : Combinational load-result formatter. Takes the assembled
//               little-endian word and the load op and returns the sign- or
//               zero-extended result.
// Ports       : i_word [31:0] assembled bytes, lane k = byte k
//               i_op   [6:0]  load op code
//               o_res  [31:0] extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_extend
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [6:0]  i_op,
    output logic [31:0] o_res
);

    always_comb begin
        o_res = i_word;
        case (i_op)
            c_op_lb:  o_res = {{24{i_word[7]}}, i_word[7:0]};
            c_op_lh:  o_res = {{16{i_word[15]}}, i_word[15:0]};
            c_op_lbu: o_res = {24'd0, i_word[7:0]};
            c_op_lhu: o_res = {16'd0, i_word[15:0]};
            default:  o_res = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Sole owner of the byte-wide RAM/IO port. Arbitrates between
//               instruction fetch (4-byte reads) and the load/store buffer
//               (1/2/4-byte accesses), serialises each access into byte
//               beats, assembles/extends read data and stalls IO stores
//               while the IO buffer is full.
// Ports       : clk, rst (async, active-high), rdy (global enable)
//               wrong_commit           - flush; aborts fetch/load in flight
//               fetch_req/addr         - fetch request (level)
//               fetch_valid/data       - fetch completion pulse + word
//               ls_enable/addr/data/is_load/op - load/store request (level)
//               ls_valid/res           - load/store completion pulse + result
//               mem_din/dout/a/wr      - byte RAM port
//               io_buffer_full         - IO write FIFO full
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int IO_SEL_HI = 17,
    parameter int IO_SEL_LO = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        wrong_commit,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_valid,
    output logic [31:0] fetch_data,
    input  logic        ls_enable,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_data,
    input  logic        ls_is_load,
    input  logic [6:0]  ls_op,
    output logic        ls_valid,
    output logic [31:0] ls_res,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    state_t      r_state, w_state;
    logic [2:0]  r_cnt, w_cnt;
    logic [31:0] r_addr, w_addr;
    logic [31:0] r_data, w_data;
    logic [6:0]  r_op, w_op;
    logic [31:0] r_buf, w_buf;
    logic [31:0] r_mem_a, w_mem_a;
    logic [7:0]  r_mem_dout, w_mem_dout;
    logic        r_mem_wr, w_mem_wr;
    logic        r_fetch_valid, w_fetch_valid;
    logic [31:0] r_fetch_data, w_fetch_data;
    logic        r_ls_valid, w_ls_valid;
    logic [31:0] r_ls_res, w_ls_res;

    logic [2:0]  w_beats;
    logic [1:0]  w_lane;
    logic [31:0] w_merged;
    logic [31:0] w_ext;
    logic        w_io_stall;

    assign w_beats    = (r_state == ST_FETCH) ? c_fetch_beats : op_beats(r_op);
    assign w_io_stall = io_buffer_full && is_io_sel(r_addr[IO_SEL_HI:IO_SEL_LO]);

    // In a read state r_cnt counts address beats already issued, so the byte
    // on mem_din belongs to lane r_cnt-1 (one cycle of RAM latency). The last
    // byte is merged straight from mem_din into the result.
    assign w_lane = r_cnt[1:0] - 2'd1;

    always_comb begin
        w_merged = r_buf;
        w_merged[{w_lane, 3'b000} +: 8] = mem_din;
    end

    mem_load_extend u_load_extend (
        .i_word (w_merged),
        .i_op   (r_op),
        .o_res  (w_ext)
    );

    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_addr        = r_addr;
        w_data        = r_data;
        w_op          = r_op;
        w_buf         = r_buf;
        w_mem_a       = r_mem_a;
        w_mem_dout    = r_mem_dout;
        w_mem_wr      = 1'b0;
        w_fetch_valid = 1'b0;
        w_fetch_data  = r_fetch_data;
        w_ls_valid    = 1'b0;
        w_ls_res      = r_ls_res;

        case (r_state)
            ST_IDLE: begin
                // A flush cycle never starts a new access
                if (!wrong_commit) begin
                    if (ls_enable) begin
                        w_addr  = ls_addr;
                        w_op    = ls_op;
                        w_data  = ls_data;
                        w_buf   = 32'd0;
                        w_cnt   = 3'd0;
                        w_mem_a = ls_addr;
                        w_state = ls_is_load ? ST_LOAD : ST_STORE;
                    end else if (fetch_req) begin
                        w_addr  = fetch_addr;
                        w_buf   = 32'd0;
                        w_cnt   = 3'd0;
                        w_mem_a = fetch_addr;
                        w_state = ST_FETCH;
                    end
                end
            end

            ST_FETCH, ST_LOAD: begin
                if (wrong_commit) begin
                    w_state = ST_IDLE;
                end else begin
                    w_cnt = r_cnt + 3'd1;
                    if (r_cnt != 3'd0) begin
                        w_buf = w_merged;
                    end
                    if (r_cnt == w_beats) begin
                        w_state = ST_IDLE;
                        if (r_state == ST_FETCH) begin
                            w_fetch_valid = 1'b1;
                            w_fetch_data  = w_merged;
                        end else begin
                            w_ls_valid = 1'b1;
                            w_ls_res   = w_ext;
                        end
                    end else if ((r_cnt + 3'd1) < w_beats) begin
                        w_mem_a = r_addr + {29'd0, r_cnt} + 32'd1;
                    end
                end
            end

            ST_STORE: begin
                // Stores have already committed, so a flush does not stop them
                if (r_cnt == w_beats) begin
                    w_state    = ST_IDLE;
                    w_ls_valid = 1'b1;
                    w_ls_res   = 32'd0;
                end else if (!w_io_stall) begin
                    w_mem_a    = r_addr + {29'd0, r_cnt};
                    w_mem_dout = r_data[{r_cnt[1:0], 3'b000} +: 8];
                    w_mem_wr   = 1'b1;
                    w_cnt      = r_cnt + 3'd1;
                end
            end

            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 3'd0;
            r_addr        <= 32'd0;
            r_data        <= 32'd0;
            r_op          <= 7'd0;
            r_buf         <= 32'd0;
            r_mem_a       <= 32'd0;
            r_mem_dout    <= 8'd0;
            r_mem_wr      <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_data  <= 32'd0;
            r_ls_valid    <= 1'b0;
            r_ls_res      <= 32'd0;
        end else if (rdy) begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_addr        <= w_addr;
            r_data        <= w_data;
            r_op          <= w_op;
            r_buf         <= w_buf;
            r_mem_a       <= w_mem_a;
            r_mem_dout    <= w_mem_dout;
            r_mem_wr      <= w_mem_wr;
            r_fetch_valid <= w_fetch_valid;
            r_fetch_data  <= w_fetch_data;
            r_ls_valid    <= w_ls_valid;
            r_ls_res      <= w_ls_res;
        end
    end

    assign mem_a       = r_mem_a;
    assign mem_dout    = r_mem_dout;
    assign mem_wr      = r_mem_wr;
    assign fetch_valid = r_fetch_valid;
    assign fetch_data  = r_fetch_data;
    assign ls_valid    = r_ls_valid;
    assign ls_res      = r_ls_res;

endmodule
`default_nettype wire
